// File: rtl/sb_pkg.sv
// Shared widths and entry layout for the store buffer and its match logic.
package sb_pkg;
  localparam int SB_DATA_W = 32;
  localparam int SB_ADDR_W = 7;
  localparam int SB_WIDX_W = SB_ADDR_W - 2;

  typedef struct packed {
    logic                 valid;
    logic [SB_WIDX_W-1:0] widx;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_match.sv
// Word-index comparator array with youngest-first priority select relative to the tail.
module sb_match #(
  parameter int DEPTH  = 4,
  parameter int WIDX_W = 5
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][WIDX_W-1:0] widx,
  input  logic [WIDX_W-1:0]            key,
  input  logic [$clog2(DEPTH)-1:0]     tail,
  input  logic                         excl_en,
  input  logic [$clog2(DEPTH)-1:0]     excl_idx,
  output logic                         hit,
  output logic [$clog2(DEPTH)-1:0]     idx
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (widx[i] == key) &&
                 !(excl_en && (excl_idx == PTR_W'(i)));
    end
  end

  // Walk oldest to youngest so the entry just behind the tail wins.
  always_comb begin
    logic [PTR_W-1:0] cand;
    cand = '0;
    hit  = 1'b0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      cand = tail - PTR_W'(k);
      if (match[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Word-granular store buffer: in-order drain to data memory, store merging,
// and load forwarding of the youngest pending value.
module store_buffer
  import sb_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DEPTH  = 4,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_stall,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_fwd_hit,
  output logic [DATA_W-1:0]        ld_fwd_data,
  input  logic                     drain_en,
  output logic                     dm_we,
  output logic [ADDR_W-1:0]        dm_waddr,
  output logic [DATA_W-1:0]        dm_wdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WIDX_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][WIDX_W-1:0] ent_widx;
  logic                         drain, push, merge_hit, m_hit, f_hit;
  logic [PTR_W-1:0]             m_idx, f_idx;

  always_comb begin
    ent_valid = '0;
    ent_widx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entries_q[i].valid;
      ent_widx[i]  = entries_q[i].widx;
    end
  end

  // The draining head is excluded so a same-word store lands in a fresh entry
  // rather than into data that is already on its way to memory.
  sb_match #(.DEPTH(DEPTH), .WIDX_W(WIDX_W)) u_merge (
    .valid    (ent_valid),
    .widx     (ent_widx),
    .key      (st_addr[ADDR_W-1:2]),
    .tail     (tail_q),
    .excl_en  (drain),
    .excl_idx (head_q),
    .hit      (m_hit),
    .idx      (m_idx)
  );

  sb_match #(.DEPTH(DEPTH), .WIDX_W(WIDX_W)) u_fwd (
    .valid    (ent_valid),
    .widx     (ent_widx),
    .key      (ld_addr[ADDR_W-1:2]),
    .tail     (tail_q),
    .excl_en  (1'b0),
    .excl_idx (head_q),
    .hit      (f_hit),
    .idx      (f_idx)
  );

  always_comb begin
    drain       = drain_en && (count_q != '0);
    merge_hit   = st_valid && m_hit;
    st_stall    = st_valid && (count_q == FULL) && !merge_hit;
    push        = st_valid && !merge_hit && !st_stall;
    dm_we       = drain;
    dm_waddr    = (count_q != '0) ? {entries_q[head_q].widx, 2'b00} : '0;
    dm_wdata    = (count_q != '0) ? entries_q[head_q].data : '0;
    ld_fwd_hit  = ld_valid && f_hit;
    ld_fwd_data = ld_fwd_hit ? entries_q[f_idx].data : '0;
    empty       = (count_q == '0);
    count       = count_q;
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(drain);
    if (drain) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PTR_W'(1);
    end
    if (merge_hit) begin
      entries_d[m_idx].data = st_data;
    end
    if (push) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].widx  = st_addr[ADDR_W-1:2];
      entries_d[tail_q].data  = st_data;
      tail_d                  = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected memory writes are queued when the
// stores are issued and checked in order as the write port fires.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, ld_valid, drain_en;
  logic [6:0]  st_addr, ld_addr;
  logic [31:0] st_data;
  logic        st_stall, ld_fwd_hit, dm_we, empty;
  logic [31:0] ld_fwd_data, dm_wdata;
  logic [6:0]  dm_waddr;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;
  logic [38:0] exp_q [$];

  store_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_stall    (st_stall),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_fwd_hit  (ld_fwd_hit),
    .ld_fwd_data (ld_fwd_data),
    .drain_en    (drain_en),
    .dm_we       (dm_we),
    .dm_waddr    (dm_waddr),
    .dm_wdata    (dm_wdata),
    .empty       (empty),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [6:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Memory samples the write port on negedge, which is where it is checked.
  always @(negedge clk) begin
    assert (!(st_valid === 1'b1 && ld_valid === 1'b1)) else begin
      failures++;
      $error("FAIL st_ld_exclusive observed=both expected=at_most_one");
    end
    if (dm_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL unexpected_write observed=%0h:%0h expected=none", dm_waddr, dm_wdata);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        assert ({dm_waddr, dm_wdata} === e) else begin
          failures++;
          $error("FAIL mem_write observed=%0h:%0h expected=%0h:%0h",
                 dm_waddr, dm_wdata, e[38:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; ld_valid = 1'b0; drain_en = 1'b0;
    st_addr = '0; st_data = '0; ld_addr = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    ld_valid = 1'b1; ld_addr = 7'h04; #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_stall", st_stall, 0);
    chk("rst_fwd_hit", ld_fwd_hit, 0);
    ld_valid = 1'b0;

    // single store, then forward
    st_valid = 1'b1; st_addr = 7'h04; st_data = 32'hAAAA0001;
    tick();
    st_valid = 1'b0;
    chk("t1_count", count, 1);
    chk("t1_empty", empty, 0);
    chk("t1_dm_we", dm_we, 0);
    ld_valid = 1'b1; ld_addr = 7'h04; #1;
    chk("t1_fwd_hit", ld_fwd_hit, 1);
    chk("t1_fwd_data", ld_fwd_data, 32'hAAAA0001);
    ld_valid = 1'b0;
    expect_wr(7'h04, 32'hAAAA0001);
    drain_en = 1'b1; #1;
    chk("t1_dm_we_on", dm_we, 1);
    tick();
    drain_en = 1'b0;
    chk("t1_drained", count, 0);

    // fill to full, fifth store stalls until a slot frees
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1;
      st_addr  = (i == 0) ? 7'h00 : 7'(4 + 4 * i);
      st_data  = 32'hD000 + 32'(i);
      tick();
    end
    st_addr = 7'h14; st_data = 32'hD004; #1;
    chk("t2_stall", st_stall, 1);
    tick();
    chk("t2_count_full", count, 4);
    expect_wr(7'h00, 32'hD000); expect_wr(7'h08, 32'hD001);
    expect_wr(7'h0C, 32'hD002); expect_wr(7'h10, 32'hD003);
    expect_wr(7'h14, 32'hD004);
    drain_en = 1'b1; #1;
    chk("t2_stall_while_drain", st_stall, 1);
    chk("t2_first_waddr", dm_waddr, 7'h00);
    tick();
    chk("t2_stall_cleared", st_stall, 0);
    tick();
    st_valid = 1'b0;
    chk("t2_count_after_accept", count, 3);
    tick(); tick(); tick();
    drain_en = 1'b0;
    chk("t2_empty", empty, 1);

    // merge of two stores to the same word
    st_valid = 1'b1; st_addr = 7'h08; st_data = 32'h11;
    tick();
    st_data = 32'h22;
    tick();
    st_valid = 1'b0;
    chk("t3_count", count, 1);
    ld_valid = 1'b1; ld_addr = 7'h08; #1;
    chk("t3_fwd_data", ld_fwd_data, 32'h22);
    ld_valid = 1'b0;
    expect_wr(7'h08, 32'h22);
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    chk("t3_count_after", count, 0);

    // store to the draining head's word is pushed, not merged
    st_valid = 1'b1; st_addr = 7'h08; st_data = 32'h11;
    tick();
    expect_wr(7'h08, 32'h11); expect_wr(7'h08, 32'h33);
    st_data = 32'h33; drain_en = 1'b1; #1;
    chk("t4_head_wdata", dm_wdata, 32'h11);
    tick();
    st_valid = 1'b0;
    chk("t4_count", count, 1);
    chk("t4_next_wdata", dm_wdata, 32'h33);
    tick();
    drain_en = 1'b0;
    chk("t4_empty", empty, 1);

    // continuous drain with interleaved stores across the pointer wrap
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 7'(32 + 4 * i); st_data = 32'hE000 + 32'(i);
      expect_wr(st_addr, st_data);
      tick();
    end
    drain_en = 1'b1;
    for (int i = 3; i < 7; i++) begin
      st_addr = 7'(32 + 4 * i); st_data = 32'hE000 + 32'(i);
      expect_wr(st_addr, st_data);
      tick();
    end
    st_valid = 1'b0;
    chk("t5_count_steady", count, 3);
    ld_valid = 1'b1; ld_addr = 7'h7C; #1;
    chk("t5_fwd_miss", ld_fwd_hit, 0);
    ld_addr = 7'h38; #1;
    chk("t5_fwd_wrap_data", ld_fwd_data, 32'hE006);
    ld_valid = 1'b0;
    tick(); tick(); tick();
    drain_en = 1'b0;
    chk("t5_empty", empty, 1);
    chk("t5_all_written", exp_q.size(), 0);

    // reset discards pending entries
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 7'(64 + 4 * i); st_data = 32'hF000 + 32'(i);
      tick();
    end
    st_valid = 1'b0;
    chk("t6_pending", count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_dm_we", dm_we, 0);
    drain_en = 1'b1; #1;
    chk("t6_dm_we_drain_en", dm_we, 0);
    tick(); tick(); tick();
    drain_en = 1'b0;
    chk("t6_no_writes", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
